// File: rtl/spi_slave_byte_if.sv
// spi_slave_byte_if
//   SPI mode-0 (CPOL=0, CPHA=0) slave. SCK, CS_n and SI are oversampled on the
//   CPU clock. RX words from the master appear on a valid/ready stream. TX words
//   from the CPU go through a one-word holding register and are shifted out on SO.
//
// Ports
//   clock     CPU clock; all flops use its rising edge
//   rst       synchronous, active-high reset
//   spi_cs_n  chip select, active low (asynchronous)
//   spi_sck   SPI clock (asynchronous)
//   spi_si    MOSI (asynchronous)
//   spi_so    MISO, registered
//   rx_data   received word; rx_valid holds it until rx_ready
//   tx_data   word offered by the CPU; tx_valid/tx_ready handshake
//   tx_ready  holding register empty
//   busy      synchronized CS active (FSM in SHIFT)
//   overrun   sticky RX overrun flag
//
// Build option
//   SPI_SLAVE_OVERRUN_EN  when defined, a word completing while rx_data is still
//                         unaccepted is dropped and overrun is raised until the
//                         next RX handshake. When undefined, the new word
//                         overwrites rx_data and overrun is tied low.
module spi_slave_byte_if #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_si,
  output logic              spi_so,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Synchronizer chains: bit 0 is the first stage, the top bit the last.
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] si_sync_q, si_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sck_prev_q, sck_prev_d;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  // Only the not-yet-complete bits are kept; the last bit comes straight from si.
  logic [DATA_W-2:0]      rx_shift_q, rx_shift_d;
  // Bits still to be sent; the current MSB already sits in spi_so_q.
  logic [DATA_W-2:0]      tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   reload_q, reload_d;
  logic                   spi_so_q, spi_so_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   busy_q, busy_d;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic                   overrun_q, overrun_d;
`endif

  logic                   cs_s, sck_s, si_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;
  logic [DATA_W-1:0]      rx_word;
  logic [DATA_W-1:0]      tx_next;
  logic                   word_done;
  logic                   consume;
  logic                   rx_hs;
  logic                   rx_drop;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign si_s     = si_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;
  assign rx_word  = {rx_shift_q, si_s};
  // Next TX word: the holding register when full, otherwise the idle pattern.
  assign tx_next  = tx_ready_q ? IDLE_BYTE : hold_q;
  assign rx_hs    = rx_valid_q & rx_ready;

  // Next-state logic: synchronizers, transfer FSM, RX/TX handshakes.
  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    si_sync_d  = {si_sync_q[SYNC_STAGES-2:0], spi_si};
    cs_prev_d  = cs_s;
    sck_prev_d = sck_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    reload_d   = reload_q;
    spi_so_d   = spi_so_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    tx_ready_d = tx_ready_q;
    word_done  = 1'b0;
    consume    = 1'b0;
    rx_drop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = {CNT_W{1'b0}};
        reload_d  = 1'b0;
        if (cs_fall) begin
          consume    = 1'b1;
          tx_shift_d = tx_next[DATA_W-2:0];
          spi_so_d   = tx_next[DATA_W-1];
          state_d    = ST_SHIFT;
        end else begin
          spi_so_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        // CS release wins over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = {CNT_W{1'b0}};
          reload_d   = 1'b0;
          rx_shift_d = {(DATA_W-1){1'b0}};
          tx_shift_d = {(DATA_W-1){1'b0}};
          spi_so_d   = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = rx_word[DATA_W-2:0];
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = {CNT_W{1'b0}};
            word_done = 1'b1;
            reload_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sck_fall) begin
          // The fall after the last bit of a word starts the next TX word.
          if (reload_q) begin
            consume    = 1'b1;
            reload_d   = 1'b0;
            tx_shift_d = tx_next[DATA_W-2:0];
            spi_so_d   = tx_next[DATA_W-1];
          end else begin
            tx_shift_d = tx_shift_q << 1;
            spi_so_d   = tx_shift_q[DATA_W-2];
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = {CNT_W{1'b0}};
        spi_so_d  = 1'b0;
      end
    endcase

    // Holding register: a consume and a load cannot coincide because a load
    // needs it empty while a consume only frees it when full.
    if (consume && !tx_ready_q) begin
      tx_ready_d = 1'b1;
    end else if (tx_valid && tx_ready_q) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end else begin
      tx_ready_d = tx_ready_q;
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    rx_drop = word_done & rx_valid_q & ~rx_ready;
`else
    rx_drop = 1'b0;
`endif

    if (word_done && !rx_drop) begin
      rx_data_d  = rx_word;
      rx_valid_d = 1'b1;
    end else if (rx_hs) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    if (rx_drop) begin
      overrun_d = 1'b1;
    end else if (rx_hs) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
`endif

    busy_d = (state_d == ST_SHIFT);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      cs_sync_q  <= {SYNC_STAGES{1'b1}};
      sck_sync_q <= {SYNC_STAGES{1'b0}};
      si_sync_q  <= {SYNC_STAGES{1'b0}};
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= {CNT_W{1'b0}};
      rx_shift_q <= {(DATA_W-1){1'b0}};
      tx_shift_q <= {(DATA_W-1){1'b0}};
      hold_q     <= {DATA_W{1'b0}};
      reload_q   <= 1'b0;
      spi_so_q   <= 1'b0;
      rx_data_q  <= {DATA_W{1'b0}};
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
      cs_sync_q  <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      si_sync_q  <= si_sync_d;
      cs_prev_q  <= cs_prev_d;
      sck_prev_q <= sck_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      reload_q   <= reload_d;
      spi_so_q   <= spi_so_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_q  <= overrun_d;
`endif
    end
  end

  assign spi_so   = spi_so_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
`ifdef SPI_SLAVE_OVERRUN_EN
  assign overrun  = overrun_q;
`else
  assign overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Bench for spi_slave_byte_if: a mode-0 SPI master plus a word-level model of
// what the slave must receive and return (holding register consumed at CS fall
// and at the end of each completed word).
module tb_spi_slave_byte_if;

  localparam int HALF = 6;  // SCK half period in CPU clocks

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       spi_cs_n = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_si = 1'b0;
  logic       spi_so;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_rx[$];   // words the CPU side must accept, in order
  logic [7:0] exp_so[$];   // word the master must read for the current word slot
  logic [7:0] m_words[$];  // words the master sends in the next frame
  logic [7:0] m_rx[$];     // words the master collected in the last frame
  bit         m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  bit         rdy_low = 1'b0;
  bit         ovr_window = 1'b0;

  spi_slave_byte_if dut (
    .clock    (clock),
    .rst      (rst),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_si   (spi_si),
    .spi_so   (spi_so),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Model: the slave takes the holding word if one is pending, else 0xFF.
  task automatic model_consume(output logic [7:0] v);
    if (m_full) begin
      v = m_hold;
      m_full = 1'b0;
    end else begin
      v = 8'hFF;
    end
  endtask

  task automatic tx_load(input logic [7:0] v);
    chk("tx_ready_model", {31'd0, tx_ready}, {31'd0, !m_full});
    if (!m_full && tx_ready) begin
      tx_data  = v;
      tx_valid = 1'b1;
      @(posedge clock);
      #2;
      tx_valid = 1'b0;
      m_hold   = v;
      m_full   = 1'b1;
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_spi_so", {31'd0, spi_so}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
  endtask

  task automatic drain_rx();
    for (int i = 0; i < 300 && exp_rx.size() != 0; i++) @(negedge clock);
    tests++;
    if (exp_rx.size() != 0) begin
      fails++;
      $display("FAIL rx_drain_timeout: got %0d words pending expected 0", exp_rx.size());
      exp_rx.delete();
    end
  endtask

  // One CS frame of nbits bits from m_words; optionally loads TX after bit load_bit-1.
  task automatic spi_frame(input int nbits, input int load_bit, input logic [7:0] load_val,
                           input bit push_rx);
    logic [7:0] so_word;
    logic [7:0] v;
    so_word = 8'h00;
    m_rx.delete();
    exp_so.delete();
    model_consume(v);
    exp_so.push_back(v);
    spi_cs_n = 1'b0;
    spi_si   = m_words[0][7];
    wait_clks(HALF);
    chk("busy_active", {31'd0, busy}, 32'd1);
    for (int b = 0; b < nbits; b++) begin
      spi_sck = 1'b1;
      so_word = {so_word[6:0], spi_so};
      if (b % 8 == 7) begin
        if (push_rx) exp_rx.push_back(m_words[b / 8]);
        v = exp_so.pop_front();
        chk("so_word", {24'd0, so_word}, {24'd0, v});
        m_rx.push_back(so_word);
      end
      wait_clks(HALF);
      spi_sck = 1'b0;
      if (b % 8 == 7) begin
        model_consume(v);
        exp_so.push_back(v);
      end
      if (b + 1 < nbits) spi_si = m_words[(b + 1) / 8][7 - ((b + 1) % 8)];
      if (b + 1 == load_bit) begin
        tx_load(load_val);
        wait_clks(HALF - 1);
      end else begin
        wait_clks(HALF);
      end
    end
    spi_cs_n = 1'b1;
    exp_so.delete();
    wait_clks(8);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("so_idle", {31'd0, spi_so}, 32'd0);
  endtask

  // rx_ready: random acceptance unless the test holds it low.
  initial forever begin
    @(posedge clock);
    #1;
    rx_ready = rdy_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Compare process: every accepted RX word against the model; overrun stays low outside the overrun test.
  initial forever begin
    @(negedge clock);
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got 0x%0h expected no word", rx_data);
        end else begin
          chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
        end
      end
      if (!ovr_window) chk("overrun_low", {31'd0, overrun}, 32'd0);
    end
  end

  initial begin
    int nw;
    int nbits;
    int lb;
    int sel;
    logic [7:0] survivor;
    logic       exp_ovr;

    // Reset values
    rst = 1'b1;
    wait_clks(3);
    check_reset_vals();
    rst = 1'b0;
    wait_clks(4);

    // TX 0xA5 loaded, master sends 0x3C
    tx_load(8'hA5);
    m_words = '{8'h3C};
    spi_frame(8, -1, 8'h00, 1'b1);
    chk("t2_master_reads", {24'd0, m_rx[0]}, 32'hA5);
    drain_rx();
    chk("t2_rx_data", {24'd0, rx_data}, 32'h3C);

    // Reset for 3 clocks in the middle of a transfer, with a word pending in TX
    spi_cs_n = 1'b0;
    spi_si   = 1'b1;
    wait_clks(HALF);
    for (int i = 0; i < 3; i++) begin
      spi_sck = 1'b1;
      wait_clks(HALF);
      spi_sck = 1'b0;
      wait_clks(HALF);
    end
    tx_load(8'h77);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      check_reset_vals();
    end
    spi_cs_n = 1'b1;
    rst      = 1'b0;
    m_full   = 1'b0;
    wait_clks(8);

    // Nothing loaded: master reads the idle pattern
    m_words = '{8'h00};
    spi_frame(8, -1, 8'h00, 1'b1);
    chk("t3_master_reads", {24'd0, m_rx[0]}, 32'hFF);
    drain_rx();
    chk("t3_rx_data", {24'd0, rx_data}, 32'h00);

    // Two words in one CS, 0x5A loaded during word 1
    m_words = '{8'h11, 8'h22};
    spi_frame(16, 3, 8'h5A, 1'b1);
    chk("t4_master_word0", {24'd0, m_rx[0]}, 32'hFF);
    chk("t4_master_word1", {24'd0, m_rx[1]}, 32'h5A);
    drain_rx();

    // Partial word aborted by CS, then a full word
    m_words = '{8'hF0};
    spi_frame(4, -1, 8'h00, 1'b1);
    m_words = '{8'h81};
    spi_frame(8, -1, 8'h00, 1'b1);
    drain_rx();
    chk("t5_rx_data", {24'd0, rx_data}, 32'h81);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      nw = $urandom_range(1, 3);
      m_words.delete();
      for (int w = 0; w < nw; w++) m_words.push_back(8'($urandom_range(0, 255)));
      nbits = (nw - 1) * 8 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8);
      sel = $urandom_range(0, 2);
      lb = -1;
      if (sel == 0) begin
        tx_load(8'($urandom_range(0, 255)));
      end else if (sel == 1) begin
        lb = 8 * $urandom_range(0, nw - 1) + $urandom_range(2, 5);
        if (lb >= nbits) lb = -1;
      end else begin
        lb = -1;
      end
      spi_frame(nbits, lb, 8'($urandom_range(0, 255)), 1'b1);
    end
    drain_rx();

    // Consumer stalled while two words arrive
    rdy_low    = 1'b1;
    ovr_window = 1'b1;
    wait_clks(2);
    m_words = '{8'h01, 8'h02};
    spi_frame(16, -1, 8'h00, 1'b0);
`ifdef SPI_SLAVE_OVERRUN_EN
    survivor = 8'h01;
    exp_ovr  = 1'b1;
`else
    survivor = 8'h02;
    exp_ovr  = 1'b0;
`endif
    chk("t6_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("t6_rx_data", {24'd0, rx_data}, {24'd0, survivor});
    chk("t6_overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    exp_rx.push_back(survivor);
    rdy_low = 1'b0;
    drain_rx();
    wait_clks(2);
    chk("t6_overrun_cleared", {31'd0, overrun}, 32'd0);
    ovr_window = 1'b0;
    wait_clks(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
